// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte engine.
// State encoding plus bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pin synchronisers and SCL edge / START / STOP detection.
// Events are combinational on the last sync stage vs. the history flop.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_h_q;
    logic                   sda_h_q;
    logic                   scl_s;

    // Left free-running so the chain tracks the real pin levels through
    // reset and no phantom edge appears when reset is released.
    always_ff @(posedge iclk) begin
        scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_h_q    <= scl_sync_q[SYNC_STAGES-1];
        sda_h_q    <= sda_sync_q[SYNC_STAGES-1];
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_h_q;
    assign scl_fall = ~scl_s & scl_h_q;
    assign start    = scl_s & scl_h_q & sda_h_q & ~sda_s;
    assign stop     = scl_s & scl_h_q & ~sda_h_q & sda_s;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave bit/byte layer: address match, write shift-in, read
// shift-out with tx latch requests, and ACK generation.
module i2c_slave_byte_engine
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iclk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic scl_rise, scl_fall, start_ev, stop_ev, sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .iclk    (iclk),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start_ev),
        .stop    (stop_ev),
        .sda_s   (sda_s)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rw_q, rw_d;
    logic       tx_req_d;

    always_ff @(posedge iclk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rw_q        <= rw_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        done_d      = done_q;
        rw_d        = rw_q;
        rx_valid_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        tx_req_d    = 1'b0;
        if (start_ev) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'd0;
            done_d      = 1'b0;
            sda_oe_d    = 1'b0;
            start_det_d = 1'b1;
            busy_d      = 1'b1;
        end else if (stop_ev) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            done_d     = 1'b0;
            sda_oe_d   = 1'b0;
            stop_det_d = 1'b1;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d = sda_s;
                            // General call (address 0) is never acknowledged.
                            if (shift_q[6:0] == SLAVE_ADDR && shift_q[6:0] != 7'd0)
                                done_d = 1'b1;
                            else
                                state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        state_d  = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q == I2C_RW_READ) begin
                            tx_req_d = 1'b1;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        state_d  = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (done_q) begin
                            done_d   = 1'b0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_READ_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK)
                            state_d = ST_WAIT_STOP;
                        else
                            done_d = 1'b1;
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        tx_req_d  = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 3'd0;
                        state_d   = ST_READ;
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Gated by reset so SDA is released without waiting for a clock edge.
    assign sda_oe    = sda_oe_q & reset;
    assign tx_req    = tx_req_d & reset;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Directed bench for i2c_slave_byte_engine with rx/tx scoreboards.
module tb_i2c_slave_byte_engine;
    import i2c_pkg::*;

    localparam int Q = 40;

    logic       iclk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       sda_bus;
    logic       sda_oe, rx_valid, tx_req, start_det, stop_det, busy;
    logic [7:0] rx_data;

    int pass_n = 0;
    int total_n = 0;
    int rx_n = 0, txr_n = 0, sd_n = 0, pd_n = 0;
    int b_rx, b_tx, b_sd, b_pd;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic       a, r;
    logic [7:0] v;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_byte_engine #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .iclk     (iclk),
        .reset    (reset),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .start_det(start_det),
        .stop_det (stop_det),
        .busy     (busy)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge iclk) begin
        if (rx_valid) begin
            rx_n++;
            chk("rx_byte", {24'd0, rx_data},
                exp_rx.size() != 0 ? {24'd0, exp_rx.pop_front()} : 32'hxxxxxxxx);
        end
        if (tx_req) txr_n++;
        if (start_det) sd_n++;
        if (stop_det) pd_n++;
    end

    task automatic snap();
        b_rx = rx_n; b_tx = txr_n; b_sd = sd_n; b_pd = pd_n;
    endtask

    task automatic bit_clk(input logic b, output logic s);
        #Q sda_m = b;
        #Q scl = 1'b1;
        #Q s = sda_bus;
        #Q scl = 1'b0;
    endtask

    task automatic start_c();
        #Q sda_m = 1'b1;
        #Q scl = 1'b1;
        #(2*Q) sda_m = 1'b0;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic stop_c();
        #Q sda_m = 1'b0;
        #Q scl = 1'b1;
        #(2*Q) sda_m = 1'b1;
        #(2*Q);
    endtask

    task automatic wr_bits(input logic [7:0] b, input int n, output logic ack);
        logic s;
        for (int i = 7; i > 7 - n; i--) bit_clk(b[i], s);
        if (n == 8) bit_clk(1'b1, ack);
        else ack = 1'b1;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        wr_bits(b, 8, ack);
    endtask

    task automatic rd_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) bit_clk(1'b1, d[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sda_oe"}, sda_oe, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_tx_req"}, tx_req, 0);
        chk({tag, "_start_det"}, start_det, 0);
        chk({tag, "_stop_det"}, stop_det, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, dut.state_q, ST_IDLE);
    endtask

    initial begin
        repeat (5) @(posedge iclk);
        #1 chk_reset_vals("rst");
        @(negedge iclk) reset = 1'b1;
        repeat (4) @(negedge iclk);

        // write 0xA5 to address 0x50
        snap();
        start_c();
        chk("t1_busy", busy, 1);
        wr_byte(8'hA0, a);
        chk("t1_addr_ack", a, ACK);
        exp_rx.push_back(8'hA5);
        wr_byte(8'hA5, a);
        chk("t1_data_ack", a, ACK);
        stop_c();
        chk("t1_rx_cnt", rx_n - b_rx, 1);
        chk("t1_rx_data", rx_data, 8'hA5);
        chk("t1_stop_cnt", pd_n - b_pd, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_state", dut.state_q, ST_IDLE);

        // address 0x51 is ignored
        snap();
        start_c();
        wr_byte(8'hA2, a);
        chk("t2_addr_nack", a, NACK);
        chk("t2_state", dut.state_q, ST_WAIT_STOP);
        wr_byte(8'h00, a);
        chk("t2_data_nack", a, NACK);
        stop_c();
        chk("t2_rx_cnt", rx_n - b_rx, 0);
        chk("t2_stop_cnt", pd_n - b_pd, 1);
        chk("t2_state_end", dut.state_q, ST_IDLE);

        // read 0x3C (ACK) then 0xC3 (NACK)
        snap();
        tx_data = 8'h3C;
        exp_tx.push_back(8'h3C);
        start_c();
        wr_byte(8'hA1, a);
        chk("t3_addr_ack", a, ACK);
        rd_byte(v);
        chk("t3_rd0", v, exp_tx.pop_front());
        tx_data = 8'hC3;
        exp_tx.push_back(8'hC3);
        bit_clk(ACK, r);
        rd_byte(v);
        chk("t3_rd1", v, exp_tx.pop_front());
        bit_clk(NACK, r);
        #Q;
        chk("t3_state", dut.state_q, ST_WAIT_STOP);
        chk("t3_sda_oe", sda_oe, 0);
        chk("t3_txreq_cnt", txr_n - b_tx, 2);
        stop_c();
        chk("t3_rx_cnt", rx_n - b_rx, 0);

        // write 0x11, repeated START, then read
        snap();
        start_c();
        wr_byte(8'hA0, a);
        chk("t4_addr_ack", a, ACK);
        exp_rx.push_back(8'h11);
        wr_byte(8'h11, a);
        chk("t4_data_ack", a, ACK);
        tx_data = 8'h5A;
        exp_tx.push_back(8'h5A);
        start_c();
        wr_byte(8'hA1, a);
        chk("t4_raddr_ack", a, ACK);
        rd_byte(v);
        chk("t4_rd", v, exp_tx.pop_front());
        bit_clk(NACK, r);
        chk("t4_rx_cnt", rx_n - b_rx, 1);
        chk("t4_rx_data", rx_data, 8'h11);
        chk("t4_start_cnt", sd_n - b_sd, 2);
        chk("t4_txreq_cnt", txr_n - b_tx, 1);
        stop_c();

        // reset in the middle of a data byte
        snap();
        start_c();
        wr_byte(8'hA0, a);
        chk("t5_addr_ack", a, ACK);
        wr_bits(8'hB0, 4, a);
        @(negedge iclk) reset = 1'b0;
        repeat (2) @(posedge iclk);
        #1 chk_reset_vals("t5");
        @(negedge iclk) reset = 1'b1;
        wr_bits(8'h50, 4, a);
        bit_clk(1'b1, r);
        chk("t5_ack_ignored", r, NACK);
        chk("t5_rx_cnt", rx_n - b_rx, 0);
        start_c();
        wr_byte(8'hA0, a);
        chk("t5_readdr_ack", a, ACK);
        stop_c();

        // STOP after three bits of a write byte
        snap();
        start_c();
        wr_byte(8'hA0, a);
        exp_rx.push_back(8'h77);
        wr_byte(8'h77, a);
        chk("t6_data_ack", a, ACK);
        wr_bits(8'h60, 3, a);
        stop_c();
        chk("t6_rx_cnt", rx_n - b_rx, 1);
        chk("t6_rx_data", rx_data, 8'h77);
        chk("t6_state", dut.state_q, ST_IDLE);
        chk("t6_busy", busy, 0);
        chk("t6_stop_cnt", pd_n - b_pd, 1);

        chk("rx_queue_empty", exp_rx.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
